// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 4-byte blocks.
// Stalls the CPU through BUSY while a miss writes back and/or fetches a block.
module dcache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSY,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [7:0]  r_valid;
  logic [7:0]  r_dirty;
  logic [2:0]  r_tag  [8];
  logic [31:0] r_data [8];

  logic [2:0]  w_tag;
  logic [2:0]  w_index;
  logic [1:0]  w_offset;
  logic [31:0] w_line;
  logic        w_hit;
  logic        w_req;

  assign w_tag    = ADDRESS[7:5];
  assign w_index  = ADDRESS[4:2];
  assign w_offset = ADDRESS[1:0];
  assign w_line   = r_data[w_index];
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_req    = READ || WRITE;
  assign READDATA = w_line[{w_offset, 3'b000} +: 8];

  always_comb begin
    w_state_next  = r_state;
    BUSY          = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'd0;
    MEM_WRITEDATA = 32'd0;
    unique case (r_state)
      StIdle: begin
        if (w_req && !w_hit) begin
          BUSY         = 1'b1;
          w_state_next = r_dirty[w_index] ? StWriteback : StFetch;
        end
      end
      StWriteback: begin
        BUSY          = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {r_tag[w_index], w_index};
        MEM_WRITEDATA = w_line;
        if (!MEM_BUSYWAIT) w_state_next = StFetch;
      end
      StFetch: begin
        BUSY        = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[7:2];
        if (!MEM_BUSYWAIT) w_state_next = StUpdate;
      end
      StUpdate: begin
        BUSY         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    // Memory request stays decoded from state until the reset edge; only the stall is masked.
    if (RESET) BUSY = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= StIdle;
      r_valid <= 8'd0;
      r_dirty <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        r_tag[i]  <= 3'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          // READ and WRITE together is handled as a store.
          if (WRITE && w_hit) begin
            r_data[w_index][{w_offset, 3'b000} +: 8] <= WRITEDATA;
            r_dirty[w_index]                         <= 1'b1;
          end
        end
        StFetch: begin
          if (!MEM_BUSYWAIT) r_data[w_index] <= MEM_READDATA;
        end
        StUpdate: begin
          r_valid[w_index] <= 1'b1;
          r_dirty[w_index] <= 1'b0;
          r_tag[w_index]   <= w_tag;
        end
        default: ;
      endcase
    end
  end

endmodule
